// File: rtl/bp_stall_counter_ctrl.sv
// Stall-accounting controller: 32 saturating live counters (31 stall reasons + instret),
// a snapshot bank, and a host command/response port. Optional macro: BP_STALL_SNAPSHOT_CLEAR_EN.
module bp_stall_counter_ctrl #(
    parameter int cnt_width_p   = 32,
    parameter int num_reasons_p = 31,
    parameter int instret_idx_p = 31
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   freeze_i,
    input  logic                   stall_v_i,
    input  logic [4:0]             stall_reason_i,
    input  logic                   instret_i,
    input  logic                   cmd_v_i,
    input  logic [1:0]             cmd_op_i,
    input  logic [4:0]             cmd_addr_i,
    output logic                   cmd_ready_o,
    output logic                   resp_v_o,
    output logic [4:0]             resp_addr_o,
    output logic [cnt_width_p-1:0] resp_data_o,
    input  logic                   resp_yumi_i,
    output logic                   overflow_o,
    output logic                   busy_o
);

    localparam int num_cnt_lp = num_reasons_p + 1;
    localparam logic [4:0] num_reasons_lw = 5'(num_reasons_p);
    localparam logic [4:0] instret_idx_lw = 5'(instret_idx_p);
    localparam logic [4:0] last_idx_lw    = 5'(num_cnt_lp - 1);

    typedef logic [cnt_width_p-1:0] cnt_t;
    localparam cnt_t cnt_max_lp = '1;

    typedef enum logic [1:0] {e_idle, e_resp, e_dump} state_e;
    typedef enum logic [1:0] {e_op_read, e_op_snap, e_op_clear, e_op_dump} op_e;

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       overflow_q, overflow_d;
    cnt_t       live_q [num_cnt_lp];
    cnt_t       live_d [num_cnt_lp];
    cnt_t       snap_q [num_cnt_lp];
    cnt_t       snap_d [num_cnt_lp];

    op_e        cmd_op;
    logic       cmd_accept;
    logic       take_snap;
    logic       clear_live;
    logic       inc_v;
    logic [4:0] inc_idx;

    assign cmd_op      = op_e'(cmd_op_i);
    assign cmd_ready_o = (state_q == e_idle);
    assign cmd_accept  = cmd_v_i & cmd_ready_o & ~reset_i;
    assign take_snap   = cmd_accept & ((cmd_op == e_op_snap) | (cmd_op == e_op_dump));

`ifdef BP_STALL_SNAPSHOT_CLEAR_EN
    assign clear_live  = cmd_accept & ((cmd_op == e_op_clear) | take_snap);
`else
    assign clear_live  = cmd_accept & (cmd_op == e_op_clear);
`endif

    // Single increment source per cycle; instret wins over a concurrent stall reason.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        inc_v   = 1'b0;
        inc_idx = '0;
        if (~reset_i & ~freeze_i) begin
            if (instret_i) begin
                inc_v   = 1'b1;
                inc_idx = instret_idx_lw;
            end else if (stall_v_i && (stall_reason_i < num_reasons_lw)) begin
                inc_v   = 1'b1;
                inc_idx = stall_reason_i;
            end
        end
    end

    // A clear on the same edge as an increment wins, so the counter reads 0 afterwards.
    always_comb begin
        overflow_d = overflow_q;
        for (int i = 0; i < num_cnt_lp; i++) begin
            live_d[i] = live_q[i];
        end
        if (clear_live) begin
            overflow_d = 1'b0;
            for (int i = 0; i < num_cnt_lp; i++) begin
                live_d[i] = '0;
            end
        end else if (inc_v) begin
            if (live_q[inc_idx] == cnt_max_lp) begin
                overflow_d = 1'b1;
            end else begin
                live_d[inc_idx] = live_q[inc_idx] + cnt_t'(1);
            end
        end
    end

    // Snapshot captures pre-increment live values.
    always_comb begin
        for (int i = 0; i < num_cnt_lp; i++) begin
            snap_d[i] = take_snap ? live_q[i] : snap_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            e_idle: begin
                if (cmd_accept) begin
                    case (cmd_op)
                        e_op_read: begin
                            state_d = e_resp;
                            idx_d   = cmd_addr_i;
                        end
                        e_op_dump: begin
                            state_d = e_dump;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            e_resp: begin
                if (resp_yumi_i) begin
                    state_d = e_idle;
                end
            end
            e_dump: begin
                if (resp_yumi_i) begin
                    if (idx_q == last_idx_lw) begin
                        state_d = e_idle;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset_i) begin
            state_q    <= e_idle;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            // NOTE: the counter banks are flops rather than a RAM, so they can and must be reset to read 0.
            for (int i = 0; i < num_cnt_lp; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            live_q     <= live_d;
            snap_q     <= snap_d;
        end
    end

    assign resp_v_o    = (state_q != e_idle);
    assign busy_o      = (state_q != e_idle);
    assign resp_addr_o = idx_q;
    assign resp_data_o = snap_q[idx_q];
    assign overflow_o  = overflow_q;

endmodule
